// File: rtl/ram_responder.sv
// Word-addressed RAM responder with a wait-state FSM and a one-cycle ready acknowledge.
// Optional RAM_RESPONDER_ERR_EN adds alignment, range and rd&wr error reporting on ram_err.
module ram_responder #(
  parameter int          DEPTH_LOG2  = 10,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        ram_clk,
  input  logic        ram_rst,
  input  logic [31:0] ram_addr,
  input  logic        ram_rd,
  input  logic        ram_wr,
  input  logic [31:0] ram_wr_data,
  output logic [31:0] ram_rd_data,
  output logic        ram_ready,
  output logic        ram_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  logic [1:0]            state_reg, state_next;
  logic [3:0]            cnt_reg, cnt_next;
  logic [31:0]           addr_reg;
  logic [31:0]           wr_data_reg;
  logic                  rd_reg, wr_reg;
  logic [31:0]           rd_data_reg;
  logic                  enter_ack;

  logic [31:0]           acc_addr;
  logic [31:0]           acc_data;
  logic                  acc_rd, acc_wr;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic                  acc_bad;
  logic                  acc_is_write, acc_is_read;
  logic                  mem_we;

  logic [31:0]           mem [0:DEPTH-1];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    enter_ack  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (ram_rd || ram_wr) begin
          if (WAIT_CYCLES == 0) begin
            state_next = S_ACK;
            enter_ack  = 1'b1;
          end else begin
            state_next = S_WAIT;
            cnt_next   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        // Requester dropping both strobes abandons the access.
        if (!ram_rd && !ram_wr) begin
          state_next = S_IDLE;
        end else if (cnt_reg == 4'd0) begin
          state_next = S_ACK;
          enter_ack  = 1'b1;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      S_ACK:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // With zero wait states the access completes straight from IDLE using the live request.
  always_comb begin
    if (state_reg == S_IDLE) begin
      acc_addr = ram_addr;
      acc_data = ram_wr_data;
      acc_rd   = ram_rd;
      acc_wr   = ram_wr;
    end else begin
      acc_addr = addr_reg;
      acc_data = wr_data_reg;
      acc_rd   = rd_reg;
      acc_wr   = wr_reg;
    end
  end

  assign acc_idx = DEPTH_LOG2'((acc_addr - BASE_ADDR) >> 2);

`ifdef RAM_RESPONDER_ERR_EN
  assign acc_bad = (acc_addr[1:0] != 2'b00)
                || (acc_addr < BASE_ADDR)
                || ((((acc_addr - BASE_ADDR) >> 2) >> DEPTH_LOG2) != 32'd0)
                || (acc_rd && acc_wr);
`else
  assign acc_bad = 1'b0;
`endif

  // Without error checking, rd&wr together resolves to a write.
  assign acc_is_write = acc_wr && !acc_bad;
  assign acc_is_read  = acc_rd && !acc_wr && !acc_bad;
  assign mem_we       = enter_ack && acc_is_write;

  always_ff @(posedge ram_clk or posedge ram_rst) begin
    if (ram_rst) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= 4'd0;
      addr_reg    <= 32'd0;
      wr_data_reg <= 32'd0;
      rd_reg      <= 1'b0;
      wr_reg      <= 1'b0;
      rd_data_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == S_IDLE && (ram_rd || ram_wr)) begin
        addr_reg    <= ram_addr;
        wr_data_reg <= ram_wr_data;
        rd_reg      <= ram_rd;
        wr_reg      <= ram_wr;
      end
      if (enter_ack && acc_is_read) begin
        rd_data_reg <= mem[acc_idx];
      end
    end
  end

  // Array is never cleared; reset on the ACK edge suppresses the write.
  always_ff @(posedge ram_clk or posedge ram_rst) begin
    if (!ram_rst && mem_we) begin
      mem[acc_idx] <= acc_data;
    end
  end

`ifdef RAM_RESPONDER_ERR_EN
  logic err_reg;

  always_ff @(posedge ram_clk or posedge ram_rst) begin
    if (ram_rst) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= enter_ack && acc_bad;
    end
  end

  assign ram_err = err_reg;
`else
  assign ram_err = 1'b0;
`endif

  assign ram_ready   = (state_reg == S_ACK);
  assign ram_rd_data = rd_data_reg;

endmodule

// File: tb/tb_ram_responder.sv
// Randomized bench for ram_responder: transaction-level memory model checked every cycle,
// plus a zero-wait-state instance for back-to-back timing.
module tb_ram_responder;

  localparam int          W    = 2;
  localparam int          DL   = 10;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata, rdata;
  logic        rd, wr, ready, err;
  logic [31:0] f_addr, f_wdata, f_rdata;
  logic        f_rd, f_wr, f_ready, f_err;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(W), .BASE_ADDR(BASE)) u_dut (
    .ram_clk(clk), .ram_rst(rst), .ram_addr(addr), .ram_rd(rd), .ram_wr(wr),
    .ram_wr_data(wdata), .ram_rd_data(rdata), .ram_ready(ready), .ram_err(err)
  );

  ram_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(0), .BASE_ADDR(BASE)) u_fast (
    .ram_clk(clk), .ram_rst(rst), .ram_addr(f_addr), .ram_rd(f_rd), .ram_wr(f_wr),
    .ram_wr_data(f_wdata), .ram_rd_data(f_rdata), .ram_ready(f_ready), .ram_err(f_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mdl [int];
  logic [31:0] exp_rd = 32'd0;
  bit          pend = 1'b0, p_abort = 1'b0, p_rd, p_wr;
  logic [31:0] p_addr, p_data;
  int          p_ack;

  function automatic bit model_err(input bit r, input bit w, input logic [31:0] a);
`ifdef RAM_RESPONDER_ERR_EN
    logic [31:0] off;
    off = a - BASE;
    return (a % 4 != 0) || (a < BASE) || ((off / 4) >= (32'd1 << DL)) || (r && w);
`else
    return (r && w && a == 32'hFFFF_FFFF && 1'b0);
`endif
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    return int'(((a - BASE) / 4) % (32'd1 << DL));
  endfunction

  // Compare process: outputs checked one step after every rising edge.
  initial begin
    bit exp_ready, exp_err;
    int idx;
    forever begin
      @(posedge clk);
      #1;
      exp_ready = 1'b0;
      exp_err   = 1'b0;
      if (pend && !p_abort && cyc == p_ack) begin
        exp_ready = 1'b1;
        exp_err   = model_err(p_rd, p_wr, p_addr);
        idx       = model_idx(p_addr);
        if (!exp_err) begin
          if (p_wr) mdl[idx] = p_data;
          else if (mdl.exists(idx)) exp_rd = mdl[idx];
        end
        pend = 1'b0;
      end
      check("ready", {31'd0, ready}, {31'd0, exp_ready});
      if (exp_ready) check("err", {31'd0, err}, {31'd0, exp_err});
      check("rd_data", rdata, exp_rd);
    end
  end

  // Issue one access; returns on the negedge where ready is expected (request already dropped).
  task automatic access(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input bit abort);
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = d;
    p_rd = r; p_wr = w; p_addr = a; p_data = d; p_abort = 1'b0;
    p_ack = cyc + 1 + W;
    pend = 1'b1;
    if (abort) begin
      @(negedge clk);
      rd = 1'b0; wr = 1'b0; p_abort = 1'b1;
      repeat (3) @(negedge clk);
      pend = 1'b0;
    end else begin
      while (cyc < p_ack) @(negedge clk);
      rd = 1'b0; wr = 1'b0;
    end
  endtask

  // ---------------- zero-wait-state monitor ----------------
  int          f_cycs[$];
  logic [31:0] f_data[$];

  always @(posedge clk) begin
    #1;
    if (f_ready) begin
      f_cycs.push_back(cyc);
      f_data.push_back(f_rdata);
    end
  end

  task automatic f_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    f_wr = 1'b1; f_addr = a; f_wdata = d;
    @(negedge clk);
    check("fast_wr_ready", {31'd0, f_ready}, 32'd1);
    f_wr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a, prev;
    int k, sel;

    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    f_rd = 1'b0; f_wr = 1'b0; f_addr = '0; f_wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ready", {31'd0, ready}, 32'd0);
      check("idle_err", {31'd0, err}, 32'd0);
      check("idle_rd_data", rdata, 32'd0);
    end

    for (int i = 0; i < 32; i++) access(1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0);

    // Write then read the same word.
    access(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
    check("wr10_ready", {31'd0, ready}, 32'd1);
    access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    check("rd10_data", rdata, 32'hDEAD_BEEF);
    check("rd10_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    check("rd10_pulse_width", {31'd0, ready}, 32'd0);

    // Aborted write leaves the old contents.
    access(1'b0, 1'b1, 32'h20, 32'hCAFE_0000, 1'b0);
    access(1'b0, 1'b1, 32'h20, 32'h1234_5678, 1'b1);
    check("abort_ready", {31'd0, ready}, 32'd0);
    access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    check("abort_rd20", rdata, 32'hCAFE_0000);

    // Out-of-range write and misaligned read.
    access(1'b0, 1'b1, 32'h0, 32'h1111_1111, 1'b0);
    access(1'b0, 1'b1, 32'h1000, 32'hA5A5_A5A5, 1'b0);
`ifdef RAM_RESPONDER_ERR_EN
    check("oor_err", {31'd0, err}, 32'd1);
`endif
    access(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
`ifdef RAM_RESPONDER_ERR_EN
    check("word0_after_oor", rdata, 32'h1111_1111);
    access(1'b1, 1'b0, 32'h3, 32'h0, 1'b0);
    check("misaligned_err", {31'd0, err}, 32'd1);
    check("misaligned_rd_hold", rdata, 32'h1111_1111);
`else
    check("word0_after_wrap", rdata, 32'hA5A5_A5A5);
    access(1'b1, 1'b0, 32'h3, 32'h0, 1'b0);
    check("misaligned_wrap_rd", rdata, 32'hA5A5_A5A5);
`endif

    // Randomized traffic.
    for (int n = 0; n < 200; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 6)      a = 32'($urandom_range(0, 31) * 4);
      else if (sel == 7) a = 32'h1000 + 32'($urandom_range(0, 31) * 4);
      else if (sel == 8) a = 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
      else               a = 32'($urandom_range(0, 1) * 4);
      k = $urandom_range(0, 19);
      if (k <= 8)       access(1'b1, 1'b0, a, $urandom, 1'b0);
      else if (k <= 16) access(1'b0, 1'b1, a, $urandom, 1'b0);
      else if (k == 17) access(1'b1, 1'b1, a, $urandom, 1'b0);
      else              access(1'b0, 1'b1, a, $urandom, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Asynchronous reset in the middle of a write's wait states.
    access(1'b0, 1'b1, 32'h8, 32'h0BAD_F00D, 1'b0);
    @(negedge clk);
    rd = 1'b0; wr = 1'b1; addr = 32'h8; wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    #2 rst = 1'b1;
    pend = 1'b0;
    exp_rd = 32'd0;
    #1;
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_rd_data", rdata, 32'd0);
    @(negedge clk);
    wr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    access(1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
    check("rst_rd8", rdata, 32'h0BAD_F00D);

    // Zero wait states: back-to-back reads are two cycles apart.
    f_write(32'h0, 32'h0000_0100);
    f_write(32'h4, 32'h0000_0200);
    @(negedge clk);
    f_cycs.delete();
    f_data.delete();
    f_rd = 1'b1; f_addr = 32'h0;
    @(negedge clk);
    f_addr = 32'h4;
    repeat (2) @(negedge clk);
    f_rd = 1'b0;
    repeat (3) @(negedge clk);
    check("fast_pulses", 32'(f_cycs.size()), 32'd2);
    if (f_cycs.size() == 2) begin
      check("fast_spacing", 32'(f_cycs[1] - f_cycs[0]), 32'd2);
      check("fast_rd0", f_data[0], 32'h0000_0100);
      check("fast_rd4", f_data[1], 32'h0000_0200);
    end
    check("fast_err", {31'd0, f_err}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
